tri_matrix_row_server: RTL

- Responder side of the row-fetch interface used by the triangular-matrix inverter.
- Holds one SIZE x SIZE complex matrix in flop storage, loaded row by row from an upstream writer.
- Once all rows are loaded, answers address requests with the full row, the echoed address tag and a valid strobe, at a fixed latency of RD_LAT cycles.
- Optionally forces the strictly-upper triangle to zero on load, so the consumer always sees a lower-triangular matrix.

---
 rtl/tri_matrix_row_server_if.sv | 27 ++
 rtl/tri_matrix_row_server.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tri_matrix_row_server_if.sv
// Row-fetch bus between the matrix row server and its writer / consumer.
// Handshake: a write moves on a cycle with wr_valid_i && wr_ready_o; requests have no backpressure.
interface tri_matrix_row_server_if #(
    parameter int SIZE = 16,
    parameter int DW   = 64,
    parameter int AW   = $clog2(SIZE)
);
    logic [SIZE*2*DW-1:0] wr_row_i;
    logic [AW-1:0]        wr_addr_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [AW-1:0]        req_addr_i;
    logic                 req_valid_i;
    logic [SIZE*2*DW-1:0] row_o;
    logic [AW-1:0]        row_addr_o;
    logic                 row_valid_o;

    modport slave (
        input  wr_row_i, wr_addr_i, wr_valid_i, req_addr_i, req_valid_i,
        output wr_ready_o, row_o, row_addr_o, row_valid_o
    );

    modport master (
        output wr_row_i, wr_addr_i, wr_valid_i, req_addr_i, req_valid_i,
        input  wr_ready_o, row_o, row_addr_o, row_valid_o
    );
endinterface

// File: rtl/tri_matrix_row_server.sv
// Holds one SIZE x SIZE complex matrix loaded row by row, then serves full rows
// with a fixed RD_LAT request-to-response latency. Optionally zeroes the upper triangle.
module tri_matrix_row_server #(
    parameter int SIZE     = 16,
    parameter int DW       = 64,
    parameter int RD_LAT   = 2,
    parameter int TRI_MASK = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    tri_matrix_row_server_if.slave  bus,
    output logic [$clog2(SIZE):0]   loaded_cnt_o,
    output logic                    ready_o,
    output logic                    err_o,
    output logic [1:0]              state_dbg_o
);
    localparam int AW = $clog2(SIZE);
    localparam int EW = 2 * DW;
    localparam int RW = SIZE * EW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(SIZE);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] bitmap_q, bitmap_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0]   addr_q [RD_LAT];
    logic [AW-1:0]   addr_d [RD_LAT];
    logic [RW-1:0]   hold_q, hold_d;
    logic [RW-1:0]   mem_q [SIZE];
    logic [RW-1:0]   mem_d [SIZE];
    logic [RW-1:0]   wr_masked;
    logic            req_fire;

    always_comb begin
        wr_masked = bus.wr_row_i;
        if (TRI_MASK != 0) begin
            for (int c = 0; c < SIZE; c++) begin
                if (c > int'(bus.wr_addr_i)) begin
                    wr_masked[c*EW +: EW] = '0;
                end
            end
        end
    end

    // Flush outranks any write or request arriving in the same cycle.
    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        mem_d    = mem_q;
        req_fire = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            bitmap_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else begin
            if (bus.req_valid_i) begin
                if (state_q == ST_SERVE) begin
                    req_fire = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            case (state_q)
                ST_EMPTY: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (bus.wr_valid_i) begin
                        mem_d[bus.wr_addr_i] = wr_masked;
                        if (!bitmap_q[bus.wr_addr_i]) begin
                            bitmap_d[bus.wr_addr_i] = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_d == FULL_CNT) begin
                            state_d = ST_SERVE;
                        end
                    end
                end
                ST_SERVE: state_d = ST_SERVE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        vld_d = '0;
        if (!flush_i) begin
            vld_d[0] = req_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
        addr_d[0] = bus.req_addr_i;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_d[i] = addr_q[i-1];
        end
    end

    // Storage is frozen while serving, so reading it at the last stage equals reading at request time.
    assign bus.row_valid_o = vld_q[RD_LAT-1];
    assign bus.row_addr_o  = addr_q[RD_LAT-1];
    assign bus.row_o       = vld_q[RD_LAT-1] ? mem_q[addr_q[RD_LAT-1]] : hold_q;
    assign hold_d          = bus.row_o;

    assign bus.wr_ready_o  = (state_q == ST_LOAD);
    assign ready_o         = (state_q == ST_SERVE);
    assign loaded_cnt_o    = cnt_q;
    assign err_o           = err_q;
    assign state_dbg_o     = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            bitmap_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            vld_q    <= '0;
            hold_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule
